// File: rtl/spi_master_multi.sv
// 4-wire SPI master with runtime CPOL/CPHA, SCLK divider, variable length and NUM_CS selects.
// Define SPI_MASTER_LSB_FIRST_EN to add the i_Lsb_First port (LSB-first transfers).
module spi_master_multi #(
  parameter int   MAX_WIDTH           = 32,
  parameter int   NUM_CS              = 4,
  parameter int   DIV_WIDTH           = 16,
  parameter logic IDLE_VALUE_for_MOSI = 1'b0,
  localparam int  LEN_W               = $clog2(MAX_WIDTH + 1),
  localparam int  CS_W                = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int  EDGE_W              = LEN_W + 1
) (
  input  logic                 c_Clk_High,
  input  logic                 i_Rst,
  input  logic                 i_Start,
  input  logic [MAX_WIDTH-1:0] i_Tx_Data,
  input  logic [LEN_W-1:0]     i_Xfer_Len,
  input  logic [CS_W-1:0]      i_Cs_Sel,
  input  logic                 i_Cpol,
  input  logic                 i_Cpha,
  input  logic [DIV_WIDTH-1:0] i_Clk_Div,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                 i_Lsb_First,
`endif
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic [MAX_WIDTH-1:0] o_Rx_Data,
  output logic                 o_SPI_Clk,
  output logic [NUM_CS-1:0]    o_SPI_CS_n,
  output logic                 o_SPI_MOSI,
  input  logic                 i_SPI_MISO
);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t               state, state_next;
  logic [DIV_WIDTH-1:0] tick_cnt, div_reg;
  logic [MAX_WIDTH-1:0] tx_reg, rx_sr, rx_data;
  logic [LEN_W-1:0]     len_reg, bit_cnt, len_in, first_idx;
  logic [EDGE_W-1:0]    edge_cnt;
  logic [NUM_CS-1:0]    cs_n, cs_dec_n;
  logic                 cpol_reg, cpha_reg, lsb_reg, lsb_in;
  logic                 sclk, mosi, busy, done;
  logic                 tick, leading, last_edge, sample_edge;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = i_Lsb_First;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic pick_bit(input logic [MAX_WIDTH-1:0] word,
                                    input logic [LEN_W-1:0] idx);
    logic [MAX_WIDTH-1:0] sh;
    sh = word >> idx;
    return sh[0];
  endfunction

  function automatic logic [LEN_W-1:0] bit_index(input logic lsb,
                                                 input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] k);
    return lsb ? k : (len - k - 1'b1);
  endfunction

  // LSB-first receive inserts at the top of the len field so the word ends right-aligned.
  function automatic logic [MAX_WIDTH-1:0] shift_in(input logic [MAX_WIDTH-1:0] sr,
                                                    input logic bit_in,
                                                    input logic lsb,
                                                    input logic [LEN_W-1:0] len);
    logic [MAX_WIDTH-1:0] ins;
    ins    = '0;
    ins[0] = bit_in;
    if (lsb) return (sr >> 1) | (ins << (len - 1'b1));
    return {sr[MAX_WIDTH-2:0], bit_in};
  endfunction

  assign tick        = (tick_cnt == '0);
  assign leading     = ~edge_cnt[0];
  assign last_edge   = (edge_cnt == ({len_reg, 1'b0} - EDGE_W'(1)));
  assign sample_edge = leading ^ cpha_reg;
  assign first_idx   = bit_index(lsb_in, len_in, '0);

  always_comb begin
    len_in = i_Xfer_Len;
    if (i_Xfer_Len == '0 || i_Xfer_Len > LEN_W'(MAX_WIDTH))
      len_in = LEN_W'(MAX_WIDTH);
  end

  // An out-of-range select matches no line, so every CS_n stays high.
  always_comb begin
    cs_dec_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (i_Cs_Sel == CS_W'(i)) cs_dec_n[i] = 1'b0;
  end

  always_ff @(posedge c_Clk_High) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_Start)           state_next = LEAD;
      LEAD:    if (tick)              state_next = XFER;
      XFER:    if (tick && last_edge) state_next = TRAIL;
      TRAIL:   if (tick)              state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge c_Clk_High) begin
    if (i_Rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      cs_n     <= '1;
      mosi     <= IDLE_VALUE_for_MOSI;
      tick_cnt <= '0;
      div_reg  <= '0;
      tx_reg   <= '0;
      rx_sr    <= '0;
      len_reg  <= '0;
      bit_cnt  <= '0;
      edge_cnt <= '0;
      cpol_reg <= 1'b0;
      cpha_reg <= 1'b0;
      lsb_reg  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        sclk <= i_Cpol;
        cs_n <= '1;
        mosi <= IDLE_VALUE_for_MOSI;
        if (i_Start) begin
          busy     <= 1'b1;
          tx_reg   <= i_Tx_Data;
          len_reg  <= len_in;
          cpol_reg <= i_Cpol;
          cpha_reg <= i_Cpha;
          div_reg  <= i_Clk_Div;
          lsb_reg  <= lsb_in;
          tick_cnt <= i_Clk_Div;
          cs_n     <= cs_dec_n;
          rx_sr    <= '0;
          bit_cnt  <= '0;
          edge_cnt <= '0;
          if (!i_Cpha) mosi <= pick_bit(i_Tx_Data, first_idx);
        end
      end else begin
        tick_cnt <= tick ? div_reg : (tick_cnt - 1'b1);
        if (tick && state == XFER) begin
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + 1'b1;
          if (sample_edge) begin
            rx_sr <= shift_in(rx_sr, i_SPI_MISO, lsb_reg, len_reg);
          end else if (cpha_reg) begin
            mosi    <= pick_bit(tx_reg, bit_index(lsb_reg, len_reg, bit_cnt));
            bit_cnt <= bit_cnt + 1'b1;
          end else if (!last_edge) begin
            mosi    <= pick_bit(tx_reg, bit_index(lsb_reg, len_reg, bit_cnt + 1'b1));
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (tick && state == TRAIL) begin
          sclk    <= cpol_reg;
          cs_n    <= '1;
          mosi    <= IDLE_VALUE_for_MOSI;
          rx_data <= rx_sr;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      end
    end
  end

  assign o_Busy     = busy;
  assign o_Done     = done;
  assign o_Rx_Data  = rx_data;
  assign o_SPI_Clk  = sclk;
  assign o_SPI_CS_n = cs_n;
  assign o_SPI_MOSI = mosi;

endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi: stimulus queues expected results, a monitor checks each o_Done.
module tb_spi_master_multi;

  logic        c_Clk_High = 1'b0;
  logic        i_Rst;
  logic        i_Start;
  logic [31:0] i_Tx_Data;
  logic [5:0]  i_Xfer_Len;
  logic [1:0]  i_Cs_Sel;
  logic        i_Cpol, i_Cpha;
  logic [15:0] i_Clk_Div;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic        i_Lsb_First;
`endif
  logic        o_Busy, o_Done, o_SPI_Clk, o_SPI_MOSI, i_SPI_MISO;
  logic [31:0] o_Rx_Data;
  logic [3:0]  o_SPI_CS_n;

  logic        use_slave;
  logic [15:0] slave_word;
  logic [15:0] slave_rx;
  logic        slave_miso;
  logic [4:0]  slave_cnt;

  typedef struct {
    logic [63:0] rx;
    logic [63:0] seq;
    int          lat;
    int          rises;
    logic [3:0]  cs_pat;
    logic        cpol;
    logic        cpha;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   n_push = 0;

  spi_master_multi dut (
    .c_Clk_High (c_Clk_High),
    .i_Rst      (i_Rst),
    .i_Start    (i_Start),
    .i_Tx_Data  (i_Tx_Data),
    .i_Xfer_Len (i_Xfer_Len),
    .i_Cs_Sel   (i_Cs_Sel),
    .i_Cpol     (i_Cpol),
    .i_Cpha     (i_Cpha),
    .i_Clk_Div  (i_Clk_Div),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .i_Lsb_First(i_Lsb_First),
`endif
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Rx_Data  (o_Rx_Data),
    .o_SPI_Clk  (o_SPI_Clk),
    .o_SPI_CS_n (o_SPI_CS_n),
    .o_SPI_MOSI (o_SPI_MOSI),
    .i_SPI_MISO (i_SPI_MISO)
  );

  always #5 c_Clk_High = ~c_Clk_High;

  always @(posedge c_Clk_High) cyc <= cyc + 1;

  assign i_SPI_MISO = use_slave ? slave_miso : o_SPI_MOSI;

  // Mode-3 slave on CS line 2: drives on falling (leading) SCLK, captures on rising.
  always @(negedge o_SPI_Clk or posedge o_SPI_CS_n[2]) begin
    if (o_SPI_CS_n[2]) begin
      slave_cnt <= 5'd0;
    end else if (slave_cnt < 5'd16) begin
      slave_miso <= slave_word[4'(5'd15 - slave_cnt)];
      slave_cnt  <= slave_cnt + 5'd1;
    end
  end

  always @(posedge o_SPI_Clk) begin
    if (!o_SPI_CS_n[2]) slave_rx <= {slave_rx[14:0], o_SPI_MOSI};
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] tx, input logic [5:0] len, input logic [1:0] sel,
                               input logic cpol, input logic cpha, input logic [15:0] div,
                               input logic [63:0] exp_rx, input logic [63:0] exp_seq,
                               input int exp_lat, input int exp_rises);
    exp_t e;
    @(negedge c_Clk_High);
    i_Cpol = cpol;
    i_Cpha = cpha;
    repeat (2) @(negedge c_Clk_High);
    i_Tx_Data  = tx;
    i_Xfer_Len = len;
    i_Cs_Sel   = sel;
    i_Clk_Div  = div;
    i_Start    = 1'b1;
    e.rx     = exp_rx;
    e.seq    = exp_seq;
    e.lat    = exp_lat;
    e.rises  = exp_rises;
    e.cs_pat = ~(4'b0001 << sel);
    e.cpol   = cpol;
    e.cpha   = cpha;
    exp_q.push_back(e);
    n_push++;
    @(negedge c_Clk_High);
    i_Start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge c_Clk_High);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      checkOutput("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge c_Clk_High);
  endtask

  // Monitor: accumulates per-transfer observations and scores them on each o_Done.
  initial begin
    logic        prev_busy = 1'b0;
    logic        prev_sclk = 1'b0;
    int          accept_cyc = 0;
    int          rises = 0;
    int          cs_low = 0;
    int          cs_bad = 0;
    logic [63:0] seq = '0;
    exp_t        e;
    forever begin
      @(negedge c_Clk_High);
      if (o_Busy && !prev_busy) begin
        accept_cyc = cyc - 1;
        rises  = 0;
        cs_low = 0;
        cs_bad = 0;
        seq    = '0;
      end
      if (o_Busy) begin
        if (o_SPI_Clk && !prev_sclk) rises++;
        if (exp_q.size() > 0 && o_SPI_Clk != prev_sclk &&
            o_SPI_Clk == (exp_q[0].cpol == exp_q[0].cpha))
          seq = {seq[62:0], o_SPI_MOSI};
        if (o_SPI_CS_n != 4'hF) cs_low++;
        if (exp_q.size() > 0 && o_SPI_CS_n != 4'hF && o_SPI_CS_n != exp_q[0].cs_pat) cs_bad++;
      end
      if (o_Done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rx_data", 64'(o_Rx_Data), e.rx);
          checkOutput("latency", 64'(cyc - accept_cyc), 64'(e.lat));
          checkOutput("sclk_rises", 64'(rises), 64'(e.rises));
          checkOutput("cs_low_cycles", 64'(cs_low), 64'(e.lat - 1));
          checkOutput("cs_wrong_line", 64'(cs_bad), 64'd0);
          checkOutput("mosi_bits", seq, e.seq);
          checkOutput("busy_at_done", 64'(o_Busy), 64'd0);
          checkOutput("cs_at_done", 64'(o_SPI_CS_n), 64'hF);
        end
      end
      prev_busy = o_Busy;
      prev_sclk = o_SPI_Clk;
    end
  end

  initial begin
    int   edges;
    logic prev;
    i_Rst      = 1'b1;
    i_Start    = 1'b0;
    i_Tx_Data  = '0;
    i_Xfer_Len = '0;
    i_Cs_Sel   = '0;
    i_Cpol     = 1'b0;
    i_Cpha     = 1'b0;
    i_Clk_Div  = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    i_Lsb_First = 1'b0;
`endif
    use_slave  = 1'b0;
    slave_word = 16'hBEEF;
    repeat (3) @(negedge c_Clk_High);
    checkOutput("rst_busy", 64'(o_Busy), 64'd0);
    checkOutput("rst_done", 64'(o_Done), 64'd0);
    checkOutput("rst_rx", 64'(o_Rx_Data), 64'd0);
    checkOutput("rst_sclk", 64'(o_SPI_Clk), 64'd0);
    checkOutput("rst_cs", 64'(o_SPI_CS_n), 64'hF);
    checkOutput("rst_mosi", 64'(o_SPI_MOSI), 64'd0);
    i_Rst = 1'b0;

    $display("[TB] mode 0 loopback, len 8, div 1");
    applyStimulus(32'hA5, 6'd8, 2'd1, 1'b0, 1'b0, 16'd1, 64'hA5, 64'hA5, 37, 8);
    waitDone(200);

    $display("[TB] mode 3 with slave model, len 16, div 0");
    use_slave = 1'b1;
    applyStimulus(32'h1234, 6'd16, 2'd2, 1'b1, 1'b1, 16'd0, 64'hBEEF, 64'h1234, 35, 16);
    waitDone(200);
    checkOutput("slave_rx", 64'(slave_rx), 64'h1234);
    checkOutput("sclk_idle_high", 64'(o_SPI_Clk), 64'd1);
    use_slave = 1'b0;

    $display("[TB] start pulsed mid-transfer is ignored");
    applyStimulus(32'h3C, 6'd8, 2'd0, 1'b0, 1'b0, 16'd2, 64'h3C, 64'h3C, 55, 8);
    repeat (20) @(negedge c_Clk_High);
    i_Tx_Data  = 32'hFF;
    i_Xfer_Len = 6'd4;
    i_Start    = 1'b1;
    @(negedge c_Clk_High);
    i_Start = 1'b0;
    waitDone(200);
    repeat (60) @(negedge c_Clk_High);

    $display("[TB] reset at 5th SCLK edge of a 32-bit transfer");
    i_Tx_Data  = 32'h12345678;
    i_Xfer_Len = 6'd32;
    i_Cs_Sel   = 2'd3;
    i_Clk_Div  = 16'd1;
    i_Start    = 1'b1;
    @(negedge c_Clk_High);
    i_Start = 1'b0;
    edges = 0;
    prev  = o_SPI_Clk;
    for (int i = 0; i < 200 && edges < 5; i++) begin
      @(negedge c_Clk_High);
      if (o_SPI_Clk != prev) edges++;
      prev = o_SPI_Clk;
    end
    checkOutput("abort_edges_seen", 64'(edges), 64'd5);
    i_Rst = 1'b1;
    @(negedge c_Clk_High);
    checkOutput("abort_cs", 64'(o_SPI_CS_n), 64'hF);
    checkOutput("abort_sclk", 64'(o_SPI_Clk), 64'd0);
    checkOutput("abort_busy", 64'(o_Busy), 64'd0);
    checkOutput("abort_done", 64'(o_Done), 64'd0);
    checkOutput("abort_rx", 64'(o_Rx_Data), 64'd0);
    repeat (2) @(negedge c_Clk_High);
    i_Rst = 1'b0;
    repeat (80) @(negedge c_Clk_High);

    $display("[TB] len 0 means full width");
    applyStimulus(32'hDEADBEEF, 6'd0, 2'd0, 1'b0, 1'b0, 16'd0, 64'hDEADBEEF, 64'hDEADBEEF, 67, 32);
    waitDone(300);

    $display("[TB] len above max clamps, mode 1");
    applyStimulus(32'hCAFEF00D, 6'd40, 2'd1, 1'b0, 1'b1, 16'd0, 64'hCAFEF00D, 64'hCAFEF00D, 67, 32);
    waitDone(300);

    $display("[TB] mode 2, len 5, upper tx bits ignored");
    applyStimulus(32'hFFFFFFF5, 6'd5, 2'd3, 1'b1, 1'b0, 16'd3, 64'h15, 64'h15, 49, 5);
    waitDone(300);

`ifdef SPI_MASTER_LSB_FIRST_EN
    $display("[TB] LSB-first loopback");
    i_Lsb_First = 1'b1;
    applyStimulus(32'h01, 6'd8, 2'd0, 1'b0, 1'b0, 16'd1, 64'h01, 64'h80, 37, 8);
    waitDone(200);
    i_Lsb_First = 1'b0;
`endif

    repeat (5) @(negedge c_Clk_High);
    checkOutput("done_pulse_count", 64'(done_cnt), 64'(n_push));
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
